rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one ROM port (2..8).
REQ-002 Parameter MXADRB, default 9: ROM address width.
REQ-003 Parameter MXDATB, default 11: ROM data width.
REQ-004 Parameter ROM_LAT, default 2: cycles from rom_ena-high cycle to rom_douta-valid cycle.
REQ-005 clka  in  1  sole clock; all logic on rising edge.
REQ-006 rsta_n  in  1  reset, synchronous, active-low.
REQ-007 req_vld  in  N_REQ  per-requester read request.
REQ-008 req_addr  in  N_REQ*MXADRB  per-requester address, requester i at bits [i*MXADRB +: MXADRB].
REQ-009 req_rdy  out  N_REQ  one-hot grant, combinational; request accepted when req_vld[i] & req_rdy[i].
REQ-010 rsp_vld  out  N_REQ  one-hot registered response strobe, one cycle.
REQ-011 rsp_data  out  MXDATB  registered read data, meaningful only when rsp_vld nonzero.
REQ-012 rom_ena  out  1  registered ROM read enable.
REQ-013 rom_addra  out  MXADRB  registered ROM address.
REQ-014 rom_douta  in  MXDATB  ROM read data.
REQ-015 pause_req  in  1  level request to quiesce the ROM port.
REQ-016 paused  out  1  registered; high only when no grants are possible and nothing is in flight.

Function
REQ-017 Arbitration SHALL be round-robin: search starts at last-granted index + 1 (mod N_REQ); first requester with req_vld high is granted.
REQ-018 At most one grant per cycle; the round-robin pointer SHALL update only on a grant.
REQ-019 req_rdy SHALL be all-zero unless state is RUN and pause_req is low.
REQ-020 A grant in cycle T SHALL produce rom_ena=1, rom_addra=granted address in cycle T+1; rom_ena=0 otherwise.
REQ-021 Response for a grant in cycle T SHALL appear in cycle T+ROM_LAT+2 (T+4 at default): rsp_vld[i]=1 for the granted i, rsp_data=rom_douta registered.
REQ-022 A requester tag pipeline of depth ROM_LAT+1 SHALL carry a valid bit and index alongside each issue; responses never reorder.
REQ-023 Back-to-back grants every cycle SHALL be sustained with one response per cycle; no buffering or backpressure on responses.
REQ-024 An in-flight counter SHALL count grants not yet responded to; simultaneous grant and response leaves it unchanged; maximum ROM_LAT+2.
REQ-025 FSM states RUN, DRAIN, PAUSED.
REQ-026 RUN -> DRAIN when pause_req=1 and in-flight count nonzero; RUN -> PAUSED when pause_req=1 and in-flight count zero.
REQ-027 DRAIN -> PAUSED when in-flight count reaches zero; DRAIN -> RUN if pause_req drops first.
REQ-028 PAUSED -> RUN when pause_req=0; paused=1 exactly while in PAUSED.
REQ-029 In DRAIN, outstanding responses SHALL still be delivered normally.

Reset
REQ-030 While rsta_n=0 at a clock edge: state=RUN, pointer=N_REQ-1 (requester 0 highest priority), in-flight=0, all tags invalid, rom_ena=0, rom_addra=0, rsp_vld=0, rsp_data=0, paused=0.
REQ-031 Reset mid-operation SHALL discard in-flight reads: no rsp_vld for any grant issued before reset, even though ROM data still emerges.
REQ-032 req_rdy SHALL be all-zero during reset cycles.

Verification
REQ-033 Single request: req_vld=0001, addr 0x005 in cycle 0 -> req_rdy=0001 cycle 0, rom_ena/rom_addra=0x005 cycle 1, rsp_vld=0001 with rom[5] in cycle 4.
REQ-034 All four requesting continuously from reset -> grants 0,1,2,3,0,... one per cycle; responses in same order, one per cycle, each 4 cycles after grant.
REQ-035 Requesters 1 and 3 only, after last grant to 2 -> next grant 3, then 1, alternating.
REQ-036 pause_req raised with 3 reads in flight -> req_rdy=0 immediately, DRAIN, 3 responses delivered, paused=1 cycle after last response; pause_req dropped -> paused=0, grants resume next cycle.
REQ-037 rsta_n low for one cycle while 2 reads in flight -> no rsp_vld in following 5 cycles without new grants; outputs at reset values; requester 0 wins first post-reset arbitration.
REQ-038 pause_req pulsed high for one cycle during DRAIN with reads in flight -> returns to RUN, paused never asserts, all responses delivered.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the shared ROM arbiter: read requests in, one-hot grants
// and registered responses out.
interface rom_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned MXADRB = 9,
  parameter int unsigned MXDATB = 11
);
  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ*MXADRB-1:0] req_addr;
  logic [N_REQ-1:0]        req_rdy;
  logic [N_REQ-1:0]        rsp_vld;
  logic [MXDATB-1:0]       rsp_data;

  modport master (
    output req_vld,
    output req_addr,
    input  req_rdy,
    input  rsp_vld,
    input  rsp_data
  );

  modport slave (
    input  req_vld,
    input  req_addr,
    output req_rdy,
    output rsp_vld,
    output rsp_data
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one fixed-latency ROM read port between N_REQ requesters,
// with a tag pipeline steering responses and a pause/drain handshake.
module rom_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned MXADRB  = 9,
  parameter int unsigned MXDATB  = 11,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic              clka,
  input  logic              rsta_n,
  rom_arbiter_if.slave      bus,
  output logic              rom_ena,
  output logic [MXADRB-1:0] rom_addra,
  input  logic [MXDATB-1:0] rom_douta,
  input  logic              pause_req,
  output logic              paused
);
  localparam int unsigned IdxW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CntW     = $clog2(ROM_LAT + 3);
  localparam int unsigned TagDepth = ROM_LAT + 1;

  typedef enum logic [1:0] {StRun, StDrain, StPaused} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, gnt_idx;
  logic              found, run_open, grant, rsp_any, paused_d, paused_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TagDepth-1:0] tag_vld_q;
  logic [IdxW-1:0]   tag_idx_q [TagDepth];
  logic              rom_ena_q;
  logic [MXADRB-1:0] rom_addra_q, gnt_addr;
  logic [N_REQ-1:0]  rsp_vld_q, rsp_vld_d;
  logic [MXDATB-1:0] rsp_data_q;
  logic [31:0]       cand;

  // Search begins one past the last granted requester
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(ptr_q) + k) % N_REQ;
      if (!found && bus.req_vld[cand[IdxW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    gnt_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IdxW'(i)) gnt_addr = bus.req_addr[i*MXADRB +: MXADRB];
    end
  end

  always_comb begin
    rsp_vld_d = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rsp_vld_d[i] = tag_vld_q[TagDepth-1] && (tag_idx_q[TagDepth-1] == IdxW'(i));
    end
  end

  assign rsp_any = |rsp_vld_q;

  always_comb begin
    cnt_d = cnt_q;
    if (grant && !rsp_any)      cnt_d = cnt_q + CntW'(1);
    else if (!grant && rsp_any) cnt_d = cnt_q - CntW'(1);
  end

  // FSM: state register
  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state_q  <= StRun;
      paused_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      paused_q <= paused_d;
    end
  end

  // FSM: next state; DRAIN leaves once the count after this cycle's response is zero
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (pause_req) state_d = (cnt_q != '0) ? StDrain : StPaused;
      StDrain: begin
        if (!pause_req)         state_d = StRun;
        else if (cnt_d == '0)   state_d = StPaused;
      end
      StPaused: if (!pause_req) state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run_open    = rsta_n && (state_q == StRun) && !pause_req;
    grant       = run_open && found;
    paused_d    = (state_d == StPaused);
    bus.req_rdy = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      bus.req_rdy[i] = grant && (gnt_idx == IdxW'(i));
    end
  end

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      ptr_q       <= IdxW'(N_REQ - 1);
      cnt_q       <= '0;
      tag_vld_q   <= '0;
      for (int unsigned i = 0; i < TagDepth; i++) tag_idx_q[i] <= '0;
      rom_ena_q   <= 1'b0;
      rom_addra_q <= '0;
      rsp_vld_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      if (grant) begin
        ptr_q       <= gnt_idx;
        rom_addra_q <= gnt_addr;
      end
      cnt_q        <= cnt_d;
      tag_vld_q[0] <= grant;
      tag_idx_q[0] <= gnt_idx;
      for (int unsigned i = 1; i < TagDepth; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
      rom_ena_q    <= grant;
      rsp_vld_q    <= rsp_vld_d;
      rsp_data_q   <= rom_douta;
    end
  end

  assign rom_ena      = rom_ena_q;
  assign rom_addra    = rom_addra_q;
  assign bus.rsp_vld  = rsp_vld_q;
  assign bus.rsp_data = rsp_data_q;
  assign paused       = paused_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: directed vector table, corner sequences and random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_rom_arbiter;
  localparam int unsigned N_REQ   = 4;
  localparam int unsigned MXADRB  = 9;
  localparam int unsigned MXDATB  = 11;
  localparam int unsigned ROM_LAT = 2;
  localparam int MRun = 0, MDrain = 1, MPaused = 2;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic              rsta_n, pause_req, rom_ena, paused;
  logic [MXADRB-1:0] rom_addra;
  logic [MXDATB-1:0] rom_douta;

  rom_arbiter_if #(.N_REQ(N_REQ), .MXADRB(MXADRB), .MXDATB(MXDATB)) bus ();

  rom_arbiter #(.N_REQ(N_REQ), .MXADRB(MXADRB), .MXDATB(MXDATB), .ROM_LAT(ROM_LAT)) dut (
    .clka      (clka),
    .rsta_n    (rsta_n),
    .bus       (bus),
    .rom_ena   (rom_ena),
    .rom_addra (rom_addra),
    .rom_douta (rom_douta),
    .pause_req (pause_req),
    .paused    (paused)
  );

  typedef struct { int due; int idx; int addr; } pend_t;
  typedef struct { bit ena; int addr; } rom_t;
  typedef struct { logic [3:0] vld; int a0; logic [3:0] exp_rdy; logic [3:0] exp_rsp; } vec_t;

  pend_t pend[$];
  rom_t  romq[$];
  int    mode, last, cyc, prev_addr, n_checks, n_fail;
  bit    prev_g, prev_rst, armed;
  logic [N_REQ-1:0] s_rdy, s_rsp;
  logic             s_paused;

  function automatic logic [MXDATB-1:0] rom_fn(input int a);
    return MXDATB'((a * 37 + 11) ^ (a >> 2));
  endfunction

  function automatic logic [N_REQ*MXADRB-1:0] ra();
    logic [N_REQ*MXADRB-1:0] r;
    for (int i = 0; i < int'(N_REQ); i++) r[i*MXADRB +: MXADRB] = MXADRB'($urandom);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive, compare against the model at negedge, advance the model.
  task automatic step(input bit rst, input bit pz, input logic [N_REQ-1:0] v,
                      input logic [N_REQ*MXADRB-1:0] a);
    rom_t r;
    bit g;
    int gi, c, infl, e_data;
    logic [N_REQ-1:0] e_rdy, e_rsp;
    rsta_n       = rst;
    pause_req    = pz;
    bus.req_vld  = v;
    bus.req_addr = a;
    r = romq.pop_front();
    rom_douta = r.ena ? rom_fn(r.addr) : MXDATB'($urandom);
    @(negedge clka);
    g = 1'b0; gi = 0; e_rdy = '0;
    if (rst && mode == MRun && !pz) begin
      for (int k = 1; k <= int'(N_REQ); k++) begin
        c = (last + k) % int'(N_REQ);
        if (!g && v[c]) begin g = 1'b1; gi = c; end
      end
    end
    if (g) e_rdy[gi] = 1'b1;
    e_rsp = '0; e_data = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e_rsp[pend[0].idx] = 1'b1;
      e_data = int'(rom_fn(pend[0].addr));
    end
    if (armed) begin
      check("req_rdy", 32'(bus.req_rdy), 32'(e_rdy));
      check("rom_ena", 32'(rom_ena), 32'(prev_g));
      if (prev_g || prev_rst) check("rom_addra", 32'(rom_addra), prev_g ? prev_addr : 0);
      check("rsp_vld", 32'(bus.rsp_vld), 32'(e_rsp));
      if (e_rsp != '0 || prev_rst) check("rsp_data", 32'(bus.rsp_data), e_data);
      check("paused", 32'(paused), 32'(mode == MPaused));
    end
    s_rdy = bus.req_rdy; s_rsp = bus.rsp_vld; s_paused = paused;
    romq.push_back('{ena: rom_ena, addr: int'(rom_addra)});
    if (!rst) begin
      mode = MRun; last = N_REQ - 1; pend.delete();
      prev_g = 1'b0; prev_addr = 0; armed = 1'b1;
    end else begin
      infl = pend.size();
      if (e_rsp != '0) void'(pend.pop_front());
      if (g) begin
        pend.push_back('{due: cyc + ROM_LAT + 2, idx: gi, addr: int'(a[gi*MXADRB +: MXADRB])});
        last = gi;
      end
      case (mode)
        MRun:   if (pz) mode = (infl != 0) ? MDrain : MPaused;
        MDrain: if (!pz) mode = MRun; else if (pend.size() == 0) mode = MPaused;
        default: if (!pz) mode = MRun;
      endcase
      prev_g = g;
      prev_addr = g ? int'(a[gi*MXADRB +: MXADRB]) : 0;
    end
    prev_rst = !rst;
    cyc++;
    @(posedge clka); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, ra());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1);
  end

  initial begin
    vec_t tbl[14];
    logic [N_REQ*MXADRB-1:0] a;
    int k, cnt_rsp, cnt_pz;
    bit pz;
    n_checks = 0; n_fail = 0; cyc = 0; armed = 1'b0; prev_g = 1'b0; prev_rst = 1'b0;
    mode = MRun; last = N_REQ - 1; prev_addr = 0;
    rsta_n = 1'b0; pause_req = 1'b0; bus.req_vld = '0; bus.req_addr = '0; rom_douta = '0;
    for (int i = 0; i < int'(ROM_LAT); i++) romq.push_back('{ena: 1'b0, addr: 0});

    tbl[0]  = '{4'b0001,  5, 4'b0001, 4'b0000};
    tbl[1]  = '{4'b0000, -1, 4'b0000, 4'b0000};
    tbl[2]  = '{4'b0000, -1, 4'b0000, 4'b0000};
    tbl[3]  = '{4'b0000, -1, 4'b0000, 4'b0000};
    tbl[4]  = '{4'b0000, -1, 4'b0000, 4'b0001};
    tbl[5]  = '{4'b1111, -1, 4'b0010, 4'b0000};
    tbl[6]  = '{4'b1111, -1, 4'b0100, 4'b0000};
    tbl[7]  = '{4'b1111, -1, 4'b1000, 4'b0000};
    tbl[8]  = '{4'b1111, -1, 4'b0001, 4'b0000};
    tbl[9]  = '{4'b0100, -1, 4'b0100, 4'b0010};
    tbl[10] = '{4'b1010, -1, 4'b1000, 4'b0100};
    tbl[11] = '{4'b1010, -1, 4'b0010, 4'b1000};
    tbl[12] = '{4'b1010, -1, 4'b1000, 4'b0001};
    tbl[13] = '{4'b0000, -1, 4'b0000, 4'b0100};

    @(posedge clka); #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0);

    for (int i = 0; i < 14; i++) begin
      a = ra();
      if (tbl[i].a0 >= 0) a[MXADRB-1:0] = MXADRB'(tbl[i].a0);
      step(1'b1, 1'b0, tbl[i].vld, a);
      check($sformatf("tbl%0d_rdy", i), 32'(s_rdy), 32'(tbl[i].exp_rdy));
      check($sformatf("tbl%0d_rsp", i), 32'(s_rsp), 32'(tbl[i].exp_rsp));
    end

    // Pause with three reads outstanding, then release
    idle(6);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b1111, ra());
    k = 0;
    step(1'b1, 1'b1, 4'b1111, ra());
    check("pause_rdy_zero", 32'(s_rdy), 0);
    while (!s_paused && k < 12) begin
      k++;
      step(1'b1, 1'b1, 4'b1111, ra());
    end
    check("pause_latency", k, 4);
    step(1'b1, 1'b0, 4'b1111, ra());
    check("still_paused", 32'(s_paused), 1);
    step(1'b1, 1'b0, 4'b1111, ra());
    check("resume_paused", 32'(s_paused), 0);
    check("resume_grant", 32'(|s_rdy), 1);

    // Reset with two reads outstanding
    idle(6);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 4'b1111, ra());
    step(1'b0, 1'b0, '0, ra());
    cnt_rsp = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0, ra());
      if (s_rsp != '0) cnt_rsp++;
    end
    check("rst_discard", cnt_rsp, 0);
    step(1'b1, 1'b0, 4'b1111, ra());
    check("rst_first_grant", 32'(s_rdy), 32'(4'b0001));

    // One-cycle pause pulse during drain
    idle(6);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'b1111, ra());
    cnt_rsp = 0; cnt_pz = 0;
    step(1'b1, 1'b1, 4'b1111, ra());
    if (s_rsp != '0) cnt_rsp++;
    if (s_paused) cnt_pz++;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, '0, ra());
      if (s_rsp != '0) cnt_rsp++;
      if (s_paused) cnt_pz++;
    end
    check("pulse_rsp_count", cnt_rsp, 3);
    check("pulse_never_paused", cnt_pz, 0);

    // Random traffic against the model
    pz = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) pz = ~pz;
      step($urandom_range(0, 79) != 0, pz, N_REQ'($urandom), ra());
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
